// File: rtl/pipo_pkg.sv
// Shared constants and helpers for the valid/ready register pipeline.
package pipo_pkg;

   localparam int N_DEFAULT     = 4;
   localparam int DEPTH_DEFAULT = 2;

   // Width needed to count 0..depth valid stages.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipo_if.sv
// Valid/ready stream bus of the pipeline: upstream, downstream, flush and occupancy.
interface pipo_if import pipo_pkg::*;
   #(parameter int N     = N_DEFAULT,
     parameter int DEPTH = DEPTH_DEFAULT);

   localparam int OW = occ_width(DEPTH);

   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  data_in;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  data_out;
   logic [OW-1:0] occupancy;

   modport master (
      output flush, in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out, occupancy
   );

   modport slave (
      input  flush, in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out, occupancy
   );

endinterface

// File: rtl/pipo_stage.sv
// One pipeline stage: a valid bit plus an N-bit word that loads on advance.
module pipo_stage #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic         advance,
   input  logic         flush,
   input  logic         valid_in,
   input  logic [N-1:0] word_in,
   output logic         valid_q,
   output logic [N-1:0] word_q
);

   logic         valid_d;
   logic [N-1:0] word_d;

   // NOTE: every output gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      if (flush) begin
         valid_d = 1'b0;
         word_d  = '0;
      end else if (advance) begin
         valid_d = valid_in;
         word_d  = valid_in ? word_in : '0;
      end
   end

   // NOTE: the data word is reset as well as the valid bit, so an empty stage always reads as zero.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

endmodule

// File: rtl/pipo_pipe.sv
// DEPTH-stage valid/ready register pipeline with flush, ready chain and occupancy count.
module pipo_pipe import pipo_pkg::*; #(
   parameter int N     = N_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input logic   clk,
   input logic   clear_n,
   pipo_if.slave bus
);

   localparam int OW = occ_width(DEPTH);

   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] can_adv;
   logic [DEPTH-1:0] load_valid;
   logic [N-1:0]     stage_word [DEPTH];
   logic [N-1:0]     load_word  [DEPTH];
   logic             chain;
   logic             in_ready;
   logic             in_xfer;
   logic             out_xfer;
   logic [OW-1:0]    occ_d;
   logic [OW-1:0]    occ_q;

   // NOTE: blocking assignments here let chain carry each stage's result to the one before it within a single pass.
   always_comb begin
      chain   = bus.out_ready;
      can_adv = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         chain      = ~stage_valid[i] | chain;
         can_adv[i] = chain;
      end
   end

   assign in_ready  = can_adv[0] & ~bus.flush & clear_n;
   assign in_xfer   = bus.in_valid & in_ready;
   assign out_xfer  = stage_valid[DEPTH-1] & bus.out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign load_valid[i] = in_xfer;
         assign load_word[i]  = bus.data_in;
      end else begin : g_body
         assign load_valid[i] = stage_valid[i-1];
         assign load_word[i]  = stage_word[i-1];
      end

      pipo_stage #(.N(N)) u_stage (
         .clk      (clk),
         .clear_n  (clear_n),
         .advance  (can_adv[i]),
         .flush    (bus.flush),
         .valid_in (load_valid[i]),
         .word_in  (load_word[i]),
         .valid_q  (stage_valid[i]),
         .word_q   (stage_word[i])
      );
   end

   // A simultaneous input and output transfer leaves the count unchanged.
   always_comb begin
      occ_d = occ_q;
      if (bus.flush) begin
         occ_d = '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) occ_q <= '0;
      else          occ_q <= occ_d;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = stage_valid[DEPTH-1];
   assign bus.data_out  = stage_word[DEPTH-1];
   assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipo_pipe.sv
// Directed checks of pipo_pipe (N=4, DEPTH=2) plus a queue-checked stream run (N=8, DEPTH=4).
module tb_pipo_pipe;

   logic clk = 1'b0;
   logic clear_a_n;
   logic clear_b_n;
   int   vectors     = 0;
   int   miscompares = 0;
   logic [7:0] sb [$];
   logic [7:0] exp_word;

   always #5 clk = ~clk;

   pipo_if #(.N(4), .DEPTH(2)) a_if ();
   pipo_if #(.N(8), .DEPTH(4)) b_if ();

   pipo_pipe #(.N(4), .DEPTH(2)) u_a (.clk(clk), .clear_n(clear_a_n), .bus(a_if));
   pipo_pipe #(.N(8), .DEPTH(4)) u_b (.clk(clk), .clear_n(clear_b_n), .bus(b_if));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of the stream run: predict ready, score outputs, then advance.
   task automatic b_cycle(input logic iv, input logic ordy, input logic [7:0] din);
      b_if.in_valid  = iv;
      b_if.out_ready = ordy;
      b_if.data_in   = din;
      #1;
      check("b_in_ready", b_if.in_ready, (sb.size() < 4) || ordy);
      if (b_if.out_valid && ordy) begin
         check("b_out_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            check("b_data_order", b_if.data_out, exp_word);
         end
      end
      if (iv && b_if.in_ready) sb.push_back(din);
      tick();
      check("b_occupancy", b_if.occupancy, sb.size());
   endtask

   initial begin
      clear_a_n      = 1'b0;
      clear_b_n      = 1'b0;
      a_if.flush     = 1'b0;
      a_if.in_valid  = 1'b0;
      a_if.data_in   = '0;
      a_if.out_ready = 1'b0;
      b_if.flush     = 1'b0;
      b_if.in_valid  = 1'b0;
      b_if.data_in   = '0;
      b_if.out_ready = 1'b0;

      // Reset state before any clock edge.
      #2;
      check("rst_out_valid", a_if.out_valid, 0);
      check("rst_data_out",  a_if.data_out,  0);
      check("rst_occupancy", a_if.occupancy, 0);
      check("rst_in_ready",  a_if.in_ready,  0);
      clear_a_n = 1'b1;
      clear_b_n = 1'b1;
      #1;
      check("rel_in_ready", a_if.in_ready, 1);

      // Stream 1,2,3 with out_ready high.
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.data_in   = 4'h1;
      tick();
      check("s_e1_out_valid", a_if.out_valid, 0);
      check("s_e1_occ",       a_if.occupancy, 1);
      a_if.data_in = 4'h2;
      tick();
      check("s_e2_out_valid", a_if.out_valid, 1);
      check("s_e2_data",      a_if.data_out,  4'h1);
      check("s_e2_occ",       a_if.occupancy, 2);
      a_if.data_in = 4'h3;
      tick();
      check("s_e3_data",      a_if.data_out,  4'h2);
      check("s_e3_occ",       a_if.occupancy, 2);
      a_if.in_valid = 1'b0;
      tick();
      check("s_e4_data",      a_if.data_out,  4'h3);
      check("s_e4_occ",       a_if.occupancy, 1);
      tick();
      check("s_empty_valid",  a_if.out_valid, 0);
      check("s_empty_data",   a_if.data_out,  0);
      check("s_empty_occ",    a_if.occupancy, 0);

      // Back-pressure: fill with A,B, hold, then push C while A leaves.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.data_in   = 4'hA;
      tick();
      a_if.data_in = 4'hB;
      tick();
      check("bp_occ_full",  a_if.occupancy, 2);
      check("bp_data_A",    a_if.data_out,  4'hA);
      a_if.data_in = 4'hC;
      #1;
      check("bp_full_ready", a_if.in_ready, 0);
      tick();
      check("bp_hold_data",  a_if.data_out,  4'hA);
      check("bp_hold_valid", a_if.out_valid, 1);
      check("bp_hold_occ",   a_if.occupancy, 2);
      a_if.out_ready = 1'b1;
      #1;
      check("bp_passthru_ready", a_if.in_ready, 1);
      tick();
      check("bp_swap_data", a_if.data_out,  4'hB);
      check("bp_swap_occ",  a_if.occupancy, 2);
      a_if.in_valid = 1'b0;
      tick();
      check("bp_data_C",    a_if.data_out,  4'hC);
      check("bp_occ_one",   a_if.occupancy, 1);
      tick();
      check("bp_drained",   a_if.occupancy, 0);

      // Flush beats a concurrent push.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.data_in   = 4'h5;
      tick();
      a_if.data_in = 4'h6;
      tick();
      check("fl_occ_full", a_if.occupancy, 2);
      check("fl_data_5",   a_if.data_out,  4'h5);
      a_if.flush   = 1'b1;
      a_if.data_in = 4'h7;
      #1;
      check("fl_in_ready", a_if.in_ready, 0);
      tick();
      check("fl_occ",       a_if.occupancy, 0);
      check("fl_out_valid", a_if.out_valid, 0);
      check("fl_data_out",  a_if.data_out,  0);
      a_if.flush     = 1'b0;
      a_if.in_valid  = 1'b0;
      a_if.out_ready = 1'b1;
      tick();
      check("fl_no7_a", a_if.out_valid, 0);
      tick();
      check("fl_no7_b", a_if.out_valid, 0);

      // Asynchronous clear mid-stream between edges.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.data_in   = 4'h9;
      tick();
      a_if.in_valid = 1'b0;
      tick();
      check("ar_held_valid", a_if.out_valid, 1);
      check("ar_held_data",  a_if.data_out,  4'h9);
      #2;
      clear_a_n = 1'b0;
      #1;
      check("ar_out_valid", a_if.out_valid, 0);
      check("ar_data_out",  a_if.data_out,  0);
      check("ar_occ",       a_if.occupancy, 0);
      check("ar_in_ready",  a_if.in_ready,  0);
      clear_a_n      = 1'b1;
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.data_in   = 4'h3;
      #1;
      check("ar_rel_ready", a_if.in_ready, 1);
      tick();
      a_if.in_valid = 1'b0;
      check("ar_first_valid", a_if.out_valid, 0);
      tick();
      check("ar_only3_valid", a_if.out_valid, 1);
      check("ar_only3_data",  a_if.data_out,  4'h3);
      tick();
      check("ar_after_valid", a_if.out_valid, 0);

      // Random valid/ready stream on the deeper, wider pipe, then drain.
      for (int c = 0; c < 1000; c++) begin
         b_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      for (int c = 0; c < 12; c++) begin
         b_cycle(1'b0, 1'b1, 8'h00);
      end
      check("b_sb_empty",  sb.size(),      0);
      check("b_final_occ", b_if.occupancy, 0);
      check("b_final_ov",  b_if.out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
